// File: rtl/issue_decode_if.sv
// Issue decode bundle: fetched instruction pair with handshake and flush in,
// per-pipe decoded fields, issue PC and halt status out.
//   master : fetch/execute side (drives instr0/instr1, pc_in, in_valid, branchTaken)
//   slave  : decoder side (drives in_ready, pipe opcodes/addresses/immediates, PCout, halted)
// Instruction words are numbered bit 0 = MSB.
interface issue_decode_if;
    logic [0:31] instr0;
    logic [0:31] instr1;
    logic [31:0] pc_in;
    logic        in_valid;
    logic        in_ready;
    logic        branchTaken;
    logic [6:0]  op_even;
    logic [6:0]  op_odd;
    logic [6:0]  RAaddr_even;
    logic [6:0]  RBaddr_even;
    logic [6:0]  RCaddr_even;
    logic [6:0]  RTaddr_even;
    logic [6:0]  RAaddr_odd;
    logic [6:0]  RBaddr_odd;
    logic [6:0]  RCaddr_odd;
    logic [6:0]  RTaddr_odd;
    logic [17:0] Imm_even;
    logic [17:0] Imm_odd;
    logic [31:0] PCout;
    logic        halted;

    modport master (
        output instr0, instr1, pc_in, in_valid, branchTaken,
        input  in_ready, op_even, op_odd,
        input  RAaddr_even, RBaddr_even, RCaddr_even, RTaddr_even,
        input  RAaddr_odd, RBaddr_odd, RCaddr_odd, RTaddr_odd,
        input  Imm_even, Imm_odd, PCout, halted
    );

    modport slave (
        input  instr0, instr1, pc_in, in_valid, branchTaken,
        output in_ready, op_even, op_odd,
        output RAaddr_even, RBaddr_even, RCaddr_even, RTaddr_even,
        output RAaddr_odd, RBaddr_odd, RCaddr_odd, RTaddr_odd,
        output Imm_even, Imm_odd, PCout, halted
    );
endinterface

// File: rtl/issue_decode.sv
// Dual-issue decoder. Buffers one fetched instruction pair and issues it to
// the even and odd pipes, in one cycle when the pair is independent and
// targets different pipes, otherwise in program order over two cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : issue_decode_if.slave (pair in, handshake, flush, decoded outputs)
// All decoded outputs are registered (one cycle after the buffer holds a slot).
module issue_decode (
    input  logic           clk,
    input  logic           reset,
    issue_decode_if.slave  bus
);
    localparam logic [6:0] OpEvenNop = 7'd85;
    localparam logic [6:0] OpOddNop  = 7'd84;
    localparam logic [6:0] OpStop    = 7'd83;

    typedef struct packed {
        logic [6:0]  op;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic [6:0]  rt;
        logic [17:0] imm;
    } pipe_t;

    function automatic pipe_t nop_out(input logic [6:0] op);
        pipe_t p;
        p     = '0;
        p.op  = op;
        return p;
    endfunction

    function automatic pipe_t decode(input logic [0:31] ins);
        pipe_t p;
        p.op  = ins[0:6];
        p.rt  = ins[7:13];
        p.rc  = ins[7:13];
        p.ra  = ins[14:20];
        p.rb  = ins[21:27];
        p.imm = ins[14:31];
        return p;
    endfunction

    // Opcodes outside both defined ranges behave as a nop of the slot's pipe.
    function automatic logic is_nop_class(input logic [6:0] op);
        return (op == 7'd0) || (op >= 7'd86);
    endfunction

    function automatic logic is_odd(input logic [6:0] op, input logic pos_odd);
        if ((op >= 7'd1 && op <= 7'd62) || op == OpEvenNop) return 1'b0;
        if (op >= 7'd63 && op <= 7'd84)                      return 1'b1;
        return pos_odd;
    endfunction

    logic [0:31] slot0_q, slot0_d, slot1_q, slot1_d;
    logic        v0_q, v0_d, v1_q, v1_d;
    logic [31:0] pc_q, pc_d;
    logic        halted_q, halted_d;
    pipe_t       even_q, even_d, odd_q, odd_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic [6:0] op0, op1;
    logic       odd0, odd1, dual, iss0, iss1, stop_iss, active, accept;

    assign op0  = slot0_q[0:6];
    assign op1  = slot1_q[0:6];
    assign odd0 = is_odd(op0, 1'b0);
    assign odd1 = is_odd(op1, 1'b1);

    // Slot1 may join slot0 only if it reads nothing slot0 writes (RC aliases RT).
    assign dual = v0_q && v1_q && (odd0 != odd1) && (op0 != OpStop)
               && (slot1_q[14:20] != slot0_q[7:13])
               && (slot1_q[21:27] != slot0_q[7:13])
               && (slot1_q[7:13]  != slot0_q[7:13]);
    assign iss0 = v0_q;
    assign iss1 = dual || (!v0_q && v1_q);
    assign stop_iss = (iss0 && op0 == OpStop) || (iss1 && op1 == OpStop);
    assign active   = !halted_q && !bus.branchTaken;

    // Ready when every valid slot leaves this edge; an issuing stop never drains.
    assign bus.in_ready = !halted_q && !reset && !stop_iss && (!v1_q || iss1);
    assign accept       = bus.in_valid && bus.in_ready && !bus.branchTaken;

    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        even_d   = nop_out(OpEvenNop);
        odd_d    = nop_out(OpOddNop);
        pc_out_d = '0;

        if (active) begin
            if (iss0) begin
                v0_d     = 1'b0;
                pc_out_d = pc_q;
                if (!is_nop_class(op0)) begin
                    if (odd0) odd_d  = decode(slot0_q);
                    else      even_d = decode(slot0_q);
                end
                if (op0 == OpStop) v1_d = 1'b0;
            end
            if (iss1) begin
                v1_d = 1'b0;
                if (!iss0) pc_out_d = pc_q + 32'd4;
                if (!is_nop_class(op1)) begin
                    if (odd1) odd_d  = decode(slot1_q);
                    else      even_d = decode(slot1_q);
                end
            end
            if (stop_iss) halted_d = 1'b1;
        end else begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end

        if (accept) begin
            slot0_d = bus.instr0;
            slot1_d = bus.instr1;
            v0_d    = 1'b1;
            v1_d    = 1'b1;
            pc_d    = bus.pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            pc_q     <= '0;
            halted_q <= 1'b0;
            even_q   <= nop_out(OpEvenNop);
            odd_q    <= nop_out(OpOddNop);
            pc_out_q <= '0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            even_q   <= even_d;
            odd_q    <= odd_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign bus.op_even     = even_q.op;
    assign bus.RAaddr_even = even_q.ra;
    assign bus.RBaddr_even = even_q.rb;
    assign bus.RCaddr_even = even_q.rc;
    assign bus.RTaddr_even = even_q.rt;
    assign bus.Imm_even    = even_q.imm;
    assign bus.op_odd      = odd_q.op;
    assign bus.RAaddr_odd  = odd_q.ra;
    assign bus.RBaddr_odd  = odd_q.rb;
    assign bus.RCaddr_odd  = odd_q.rc;
    assign bus.RTaddr_odd  = odd_q.rt;
    assign bus.Imm_odd     = odd_q.imm;
    assign bus.PCout       = pc_out_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_issue_decode.sv
module tb_issue_decode;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    issue_decode_if bus ();

    issue_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:31] mk(input logic [6:0] op, input logic [6:0] rt,
                                       input logic [6:0] ra, input logic [6:0] rb);
        logic [0:31] w;
        w = {op, rt, ra, rb, 4'b0000};
        return w;
    endfunction

    // Presents a pair on a falling edge; the next rising edge may capture it.
    task automatic present(input logic [0:31] i0, input logic [0:31] i1, input logic [31:0] pc);
        bus.instr0   = i0;
        bus.instr1   = i1;
        bus.pc_in    = pc;
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd85) begin errors++;
            $display("FAIL reset_op_even got %0d want 85", bus.op_even); end
        checks++; if (bus.op_odd !== 7'd84) begin errors++;
            $display("FAIL reset_op_odd got %0d want 84", bus.op_odd); end
        checks++; if (bus.PCout !== 32'd0 || bus.RTaddr_even !== 7'd0 || bus.Imm_odd !== 18'd0)
            begin errors++; $display("FAIL reset_zero PCout=%0h RT=%0d Imm=%0h want 0",
                bus.PCout, bus.RTaddr_even, bus.Imm_odd); end
        checks++; if (bus.in_ready !== 1'b0 || bus.halted !== 1'b0) begin errors++;
            $display("FAIL reset_ready_halt ready=%0b halted=%0b want 0 0",
                bus.in_ready, bus.halted); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_dual;
        present(mk(7'd3, 7'd5, 7'd2, 7'd3), mk(7'd66, 7'd8, 7'd6, 7'd7), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.op_even !== 7'd85) begin errors++;
            $display("FAIL dual_latency op_even got %0d want 85", bus.op_even); end
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd3 || bus.RTaddr_even !== 7'd5 || bus.RCaddr_even !== 7'd5
            || bus.RAaddr_even !== 7'd2 || bus.RBaddr_even !== 7'd3) begin errors++;
            $display("FAIL dual_even op=%0d rt=%0d rc=%0d ra=%0d rb=%0d want 3 5 5 2 3",
                bus.op_even, bus.RTaddr_even, bus.RCaddr_even, bus.RAaddr_even, bus.RBaddr_even); end
        checks++; if (bus.op_odd !== 7'd66 || bus.RTaddr_odd !== 7'd8 || bus.RAaddr_odd !== 7'd6
            || bus.Imm_odd !== {7'd6, 7'd7, 4'd0}) begin errors++;
            $display("FAIL dual_odd op=%0d rt=%0d ra=%0d imm=%0h want 66 8 6 %0h",
                bus.op_odd, bus.RTaddr_odd, bus.RAaddr_odd, bus.Imm_odd, {7'd6, 7'd7, 4'd0}); end
        checks++; if (bus.PCout !== 32'd0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL dual_pc_ready PCout=%0h ready=%0b want 0 1", bus.PCout, bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd85 || bus.op_odd !== 7'd84 || bus.RTaddr_even !== 7'd0)
            begin errors++; $display("FAIL dual_idle even=%0d odd=%0d rt=%0d want 85 84 0",
                bus.op_even, bus.op_odd, bus.RTaddr_even); end
    endtask

    task automatic test_two_even;
        present(mk(7'd1, 7'd1, 7'd0, 7'd0), mk(7'd1, 7'd2, 7'd0, 7'd0), 32'h40);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL two_even_ready_full got %0b want 0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd1 || bus.RTaddr_even !== 7'd1 || bus.op_odd !== 7'd84
            || bus.PCout !== 32'h40) begin errors++;
            $display("FAIL two_even_first even=%0d rt=%0d odd=%0d pc=%0h want 1 1 84 40",
                bus.op_even, bus.RTaddr_even, bus.op_odd, bus.PCout); end
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd1 || bus.RTaddr_even !== 7'd2 || bus.op_odd !== 7'd84
            || bus.PCout !== 32'h44) begin errors++;
            $display("FAIL two_even_second even=%0d rt=%0d odd=%0d pc=%0h want 1 2 84 44",
                bus.op_even, bus.RTaddr_even, bus.op_odd, bus.PCout); end
        @(negedge clk);
    endtask

    task automatic test_raw;
        present(mk(7'd1, 7'd2, 7'd0, 7'd0), mk(7'd66, 7'd0, 7'd2, 7'd0), 32'h80);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd1 || bus.op_odd !== 7'd84 || bus.PCout !== 32'h80)
            begin errors++; $display("FAIL raw_first even=%0d odd=%0d pc=%0h want 1 84 80",
                bus.op_even, bus.op_odd, bus.PCout); end
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd85 || bus.op_odd !== 7'd66 || bus.RAaddr_odd !== 7'd2
            || bus.PCout !== 32'h84) begin errors++;
            $display("FAIL raw_second even=%0d odd=%0d ra=%0d pc=%0h want 85 66 2 84",
                bus.op_even, bus.op_odd, bus.RAaddr_odd, bus.PCout); end
        @(negedge clk);
    endtask

    task automatic test_flush;
        present(mk(7'd1, 7'd3, 7'd0, 7'd0), mk(7'd1, 7'd4, 7'd0, 7'd0), 32'hC0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd1 || bus.RTaddr_even !== 7'd3) begin errors++;
            $display("FAIL flush_first even=%0d rt=%0d want 1 3", bus.op_even, bus.RTaddr_even); end
        // Flush together with a competing pair: the pair must be refused.
        bus.branchTaken = 1'b1;
        present(mk(7'd9, 7'd9, 7'd0, 7'd0), mk(7'd70, 7'd1, 7'd0, 7'd0), 32'h900);
        @(negedge clk);
        bus.branchTaken = 1'b0;
        checks++; if (bus.op_even !== 7'd85 || bus.op_odd !== 7'd84 || bus.RTaddr_even !== 7'd0
            || bus.PCout !== 32'd0) begin errors++;
            $display("FAIL flush_nop even=%0d odd=%0d rt=%0d pc=%0h want 85 84 0 0",
                bus.op_even, bus.op_odd, bus.RTaddr_even, bus.PCout); end
        present(mk(7'd2, 7'd6, 7'd0, 7'd0), mk(7'd70, 7'd7, 7'd0, 7'd0), 32'h200);
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL flush_ready got %0b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.op_even !== 7'd85 || bus.op_odd !== 7'd84) begin errors++;
            $display("FAIL flush_refused even=%0d odd=%0d want 85 84", bus.op_even, bus.op_odd); end
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd2 || bus.op_odd !== 7'd70 || bus.PCout !== 32'h200)
            begin errors++; $display("FAIL flush_new_pair even=%0d odd=%0d pc=%0h want 2 70 200",
                bus.op_even, bus.op_odd, bus.PCout); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        present(mk(7'd1, 7'd5, 7'd0, 7'd0), mk(7'd1, 7'd6, 7'd0, 7'd0), 32'h300);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd1 || bus.RTaddr_even !== 7'd5) begin errors++;
            $display("FAIL rmid_first even=%0d rt=%0d want 1 5", bus.op_even, bus.RTaddr_even); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd85 || bus.op_odd !== 7'd84 || bus.RTaddr_even !== 7'd0
            || bus.PCout !== 32'd0 || bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL rmid_reset even=%0d odd=%0d rt=%0d pc=%0h ready=%0b want 85 84 0 0 0",
                bus.op_even, bus.op_odd, bus.RTaddr_even, bus.PCout, bus.in_ready); end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.op_even !== 7'd85 || bus.RTaddr_even !== 7'd0) begin errors++;
                $display("FAIL rmid_pending cycle=%0d even=%0d rt=%0d want 85 0",
                    i, bus.op_even, bus.RTaddr_even); end
        end
    endtask

    task automatic test_stop;
        present(mk(7'd85, 7'd9, 7'd0, 7'd0), mk(7'd83, 7'd0, 7'd0, 7'd0), 32'h400);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL stop_ready_full got %0b want 0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.op_even !== 7'd85 || bus.op_odd !== 7'd83 || bus.PCout !== 32'h400)
            begin errors++; $display("FAIL stop_dual even=%0d odd=%0d pc=%0h want 85 83 400",
                bus.op_even, bus.op_odd, bus.PCout); end
        checks++; if (bus.halted !== 1'b1 || bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL stop_halted halted=%0b ready=%0b want 1 0", bus.halted, bus.in_ready); end
        present(mk(7'd3, 7'd1, 7'd0, 7'd0), mk(7'd66, 7'd2, 7'd0, 7'd0), 32'h500);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++; if (bus.op_even !== 7'd85 || bus.op_odd !== 7'd84 || bus.in_ready !== 1'b0
                || bus.halted !== 1'b1) begin errors++;
                $display("FAIL stop_hold cycle=%0d even=%0d odd=%0d ready=%0b halted=%0b want 85 84 0 1",
                    i, bus.op_even, bus.op_odd, bus.in_ready, bus.halted); end
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.halted !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL stop_cleared halted=%0b ready=%0b want 0 1", bus.halted, bus.in_ready); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.instr0      = '0;
        bus.instr1      = '0;
        bus.pc_in       = '0;
        bus.in_valid    = 1'b0;
        bus.branchTaken = 1'b0;
        test_reset();
        test_dual();
        test_two_even();
        test_raw();
        test_flush();
        test_reset_mid();
        test_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
